// File: rtl/conv_window_gen_if.sv
// ============================================================================
//  Module   : conv_window_gen_if
//  Purpose  : Pixel-in / window-out bundle for conv_window_gen.
//             master = pixel source and window consumer, slave = generator.
//  Signals  : d_in      pixel, channel c at [c*N +: N]
//             sof       start of frame, qualified by en_in
//             en_in     pixel valid strobe
//             data2conv packed KERNEL x KERNEL x CL_IN window
//             en_out    one-cycle window valid strobe
//             last_win  final window of a frame (only with WIN_LAST_EN)
//  Macros   : WIN_LAST_EN adds last_win
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface conv_window_gen_if #(
    parameter int CL_IN  = 1,
    parameter int KERNEL = 3,
    parameter int N      = 4
);
    logic [CL_IN*N-1:0]               d_in;
    logic                             sof;
    logic                             en_in;
    logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv;
    logic                             en_out;
`ifdef WIN_LAST_EN
    logic                             last_win;
`endif

    modport master (
        output d_in,
        output sof,
        output en_in,
`ifdef WIN_LAST_EN
        input  last_win,
`endif
        input  data2conv,
        input  en_out
    );

    modport slave (
        input  d_in,
        input  sof,
        input  en_in,
`ifdef WIN_LAST_EN
        output last_win,
`endif
        output data2conv,
        output en_out
    );
endinterface

`default_nettype wire

// File: rtl/conv_window_gen.sv
// ============================================================================
//  Module   : conv_window_gen
//  Purpose  : Streaming sliding-window generator for a "valid" convolution.
//             Buffers KERNEL-1 lines of IMG_W pixels and emits every complete
//             KERNEL x KERNEL x CL_IN window, one clock after the pixel that
//             completes it.
//  Ports    : clk  clock, rising edge
//             rst  synchronous active-high reset
//             bus  conv_window_gen_if.slave (d_in, sof, en_in in;
//                  data2conv, en_out [, last_win] out)
//  Macros   : WIN_LAST_EN adds bus.last_win, high with the frame's last window
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_window_gen #(
    parameter int CL_IN  = 1,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 4
) (
    input  logic              clk,
    input  logic              rst,
    conv_window_gen_if.slave  bus
);
    localparam int PW = CL_IN * N;
    localparam int WW = CL_IN * KERNEL * KERNEL * N;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, pos_col;
    logic [RW-1:0] row_q, row_d, pos_row;
    logic [WW-1:0] win_q, win_d;
    logic [WW-1:0] data2conv_q, data2conv_d;
    logic          en_out_q, en_out_d;
`ifdef WIN_LAST_EN
    logic          last_win_q, last_win_d;
`endif

    // Incoming column for the window; index r = window row, 0 = oldest line.
    logic [PW-1:0] col_new [KERNEL];

    // sof forces the accepted pixel to (0,0) regardless of the counters.
    assign pos_col = bus.sof ? '0 : col_q;
    assign pos_row = bus.sof ? '0 : row_q;

    assign col_new[KERNEL-1] = bus.d_in;

    generate
        if (KERNEL > 1) begin : g_lb
            // lb_mem[0] holds the previous line, lb_mem[KERNEL-2] the oldest.
            // Not reset: stale contents are never reachable before the row
            // counter has refilled every buffer line in use.
            logic [PW-1:0] lb_mem [KERNEL-1][IMG_W];

            always_ff @(posedge clk) begin
                if (!rst && bus.en_in) begin
                    lb_mem[0][pos_col] <= bus.d_in;
                    for (int j = 1; j < KERNEL - 1; j++) begin
                        lb_mem[j][pos_col] <= lb_mem[j-1][pos_col];
                    end
                end
            end

            for (genvar r = 0; r < KERNEL - 1; r++) begin : g_tap
                assign col_new[r] = lb_mem[KERNEL-2-r][pos_col];
            end
        end
    endgenerate

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        data2conv_d = data2conv_q;
        en_out_d    = 1'b0;
`ifdef WIN_LAST_EN
        last_win_d  = 1'b0;
`endif
        if (bus.en_in) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end

            // Shift every window row left by one column, new column at k=K-1.
            for (int c = 0; c < CL_IN; c++) begin
                for (int r = 0; r < KERNEL; r++) begin
                    for (int k = 0; k < KERNEL; k++) begin
                        if (k < KERNEL - 1) begin
                            win_d[((c*KERNEL+r)*KERNEL+k)*N +: N] =
                                win_q[((c*KERNEL+r)*KERNEL+k+1)*N +: N];
                        end else begin
                            win_d[((c*KERNEL+r)*KERNEL+k)*N +: N] =
                                col_new[r][c*N +: N];
                        end
                    end
                end
            end

            // Column gate keeps windows from straddling a line boundary.
            if (int'(pos_row) >= KERNEL - 1 && int'(pos_col) >= KERNEL - 1) begin
                en_out_d    = 1'b1;
                data2conv_d = win_d;
            end
`ifdef WIN_LAST_EN
            last_win_d = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            data2conv_q <= '0;
            en_out_q    <= 1'b0;
`ifdef WIN_LAST_EN
            last_win_q  <= 1'b0;
`endif
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            data2conv_q <= data2conv_d;
            en_out_q    <= en_out_d;
`ifdef WIN_LAST_EN
            last_win_q  <= last_win_d;
`endif
        end
    end

    assign bus.data2conv = data2conv_q;
    assign bus.en_out    = en_out_q;
`ifdef WIN_LAST_EN
    assign bus.last_win  = last_win_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// ============================================================================
//  Module   : tb_conv_window_gen
//  Purpose  : Self-checking bench for conv_window_gen. A frame-array model
//             predicts en_out / data2conv (/ last_win) for every cycle;
//             directed frames plus randomized traffic with gaps and sof.
//  Macros   : WIN_LAST_EN builds the last_win variant with CL_IN=2
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_window_gen;
    localparam int KERNEL = 3;
    localparam int N      = 4;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 4;
`ifdef WIN_LAST_EN
    localparam int CL_IN  = 2;
`else
    localparam int CL_IN  = 1;
`endif
    localparam int PW = CL_IN * N;
    localparam int WW = CL_IN * KERNEL * KERNEL * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_gen_if #(.CL_IN(CL_IN), .KERNEL(KERNEL), .N(N)) bus ();

    conv_window_gen #(
        .CL_IN (CL_IN),
        .KERNEL(KERNEL),
        .N     (N),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- model state ----------------
    int          frame [IMG_H][IMG_W][CL_IN];
    int          mrow, mcol;
    logic        exp_en, exp_last;
    logic [WW-1:0] exp_data;
    bit          chk_on   = 1'b0;
    bit          gap_mode = 1'b0;
    int          acc_cnt  = 0;

    typedef struct {
        int            acc;
        logic [WW-1:0] data;
        bit            last;
    } win_t;
    win_t win_log[$];
    logic prev_en = 1'b0;

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            tests++;
            if (bus.en_out !== exp_en) begin
                fails++;
                $display("FAIL en_out t=%0t got %b want %b", $time, bus.en_out, exp_en);
            end
            tests++;
            if (bus.data2conv !== exp_data) begin
                fails++;
                $display("FAIL data2conv t=%0t got %h want %h", $time, bus.data2conv, exp_data);
            end
`ifdef WIN_LAST_EN
            tests++;
            if (bus.last_win !== exp_last) begin
                fails++;
                $display("FAIL last_win t=%0t got %b want %b", $time, bus.last_win, exp_last);
            end
`endif
            if (gap_mode && bus.en_out === 1'b1) begin
                tests++;
                if (prev_en === 1'b1) begin
                    fails++;
                    $display("FAIL en_out_consecutive t=%0t got 1 want 0", $time);
                end
            end
            if (bus.en_out === 1'b1) begin
                win_t w;
                w.acc  = acc_cnt;
                w.data = bus.data2conv;
`ifdef WIN_LAST_EN
                w.last = bus.last_win;
`else
                w.last = 1'b0;
`endif
                win_log.push_back(w);
            end
        end
        prev_en = bus.en_out;
    end

    // ---------------- model ----------------
    task automatic model_accept(input bit s, input logic [PW-1:0] v);
        if (s) begin
            mrow = 0;
            mcol = 0;
        end
        for (int c = 0; c < CL_IN; c++) frame[mrow][mcol][c] = int'(v[c*N +: N]);
        if (mrow >= KERNEL - 1 && mcol >= KERNEL - 1) begin
            exp_en = 1'b1;
            for (int c = 0; c < CL_IN; c++)
                for (int r = 0; r < KERNEL; r++)
                    for (int k = 0; k < KERNEL; k++)
                        exp_data[((c*KERNEL+r)*KERNEL+k)*N +: N] =
                            N'(frame[mrow-KERNEL+1+r][mcol-KERNEL+1+k][c]);
            exp_last = (mrow == IMG_H - 1) && (mcol == IMG_W - 1);
        end else begin
            exp_en   = 1'b0;
            exp_last = 1'b0;
        end
        mcol++;
        if (mcol == IMG_W) begin
            mcol = 0;
            mrow++;
            if (mrow == IMG_H) mrow = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [PW-1:0] pix(input int p);
        logic [PW-1:0] v;
        for (int c = 0; c < CL_IN; c++) v[c*N +: N] = N'((p + c) % 16);
        return v;
    endfunction

    // Hand-computed first window of a 5-wide frame (values p = row*5+col):
    // rows 0..2, cols 0..2 -> 0,1,2 / 5,6,7 / 10,11,12, shifted by off.
    function automatic logic [WW-1:0] lit_win(input int off);
        int            lit [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        logic [WW-1:0] v;
        for (int c = 0; c < CL_IN; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    v[((c*3+r)*3+k)*N +: N] = N'((lit[r*3+k] + off + c) % 16);
        return v;
    endfunction

    function automatic win_t win_at(input int i);
        win_t w;
        w.acc  = -1;
        w.data = '0;
        w.last = 1'b0;
        if (i < win_log.size()) w = win_log[i];
        return w;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_vec(input string name, input logic [WW-1:0] got, input logic [WW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic step(input bit en, input bit s, input logic [PW-1:0] v);
        @(negedge clk);
        #1;
        rst       = 1'b0;
        bus.en_in = en;
        bus.sof   = s;
        bus.d_in  = v;
        if (en) begin
            acc_cnt++;
            model_accept(s, v);
        end else begin
            exp_en   = 1'b0;
            exp_last = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst       = 1'b1;
        bus.en_in = 1'b0;
        bus.sof   = 1'b0;
        bus.d_in  = '0;
        exp_en    = 1'b0;
        exp_last  = 1'b0;
        exp_data  = '0;
        mrow      = 0;
        mcol      = 0;
        chk_on    = 1'b1;
    endtask

    task automatic run_frame(input bit gaps, input bit first_sof, input int off);
        for (int p = 0; p < IMG_W * IMG_H; p++) begin
            if (gaps) step(1'b0, 1'b0, '0);
            step(1'b1, first_sof && (p == 0), pix(p + off));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0, a0, nlast;
        rst       = 1'b1;
        bus.en_in = 1'b0;
        bus.sof   = 1'b0;
        bus.d_in  = '0;
        exp_en    = 1'b0;
        exp_last  = 1'b0;
        exp_data  = '0;

        do_reset();

        // 1: continuous frame
        s0 = win_log.size();
        a0 = acc_cnt;
        run_frame(1'b0, 1'b1, 0);
        idle(2);
        chk("t1_window_count", win_log.size() - s0, 6);
        chk("t1_first_latency_pixels", win_at(s0).acc - a0, 13);
        chk_vec("t1_first_window", win_at(s0).data, lit_win(0));
`ifdef WIN_LAST_EN
        nlast = 0;
        for (int i = 0; i < 6; i++) nlast += int'(win_at(s0 + i).last);
        chk("t6_last_count", nlast, 1);
        chk("t6_last_on_sixth", int'(win_at(s0 + 5).last), 1);
`endif

        // 2: en_in low every other cycle
        s0 = win_log.size();
        gap_mode = 1'b1;
        run_frame(1'b1, 1'b1, 0);
        idle(2);
        gap_mode = 1'b0;
        chk("t2_window_count", win_log.size() - s0, 6);
        chk_vec("t2_first_window", win_at(s0).data, lit_win(0));

        // 3: two frames back to back, sof only on the first
        s0 = win_log.size();
        run_frame(1'b0, 1'b1, 0);
        run_frame(1'b0, 1'b0, 3);
        idle(2);
        chk("t3_window_count", win_log.size() - s0, 12);
        chk_vec("t3_frame2_first_window", win_at(s0 + 6).data, lit_win(3));
`ifdef WIN_LAST_EN
        chk("t6_last_frame2", int'(win_at(s0 + 11).last), 1);
        chk("t6_not_last_frame2_first", int'(win_at(s0 + 6).last), 0);
`endif

        // 4: sof on pixel 7 of a frame restarts the counters
        s0 = win_log.size();
        a0 = acc_cnt;
        for (int p = 0; p < 7; p++) step(1'b1, p == 0, pix(p));
        run_frame(1'b0, 1'b1, 8);
        idle(2);
        chk("t4_window_count", win_log.size() - s0, 6);
        chk("t4_pixels_after_sof", win_at(s0).acc - (a0 + 8), 12);
        chk_vec("t4_first_window", win_at(s0).data, lit_win(8));

        // 5: reset after pixel 13, then a frame without sof
        s0 = win_log.size();
        for (int p = 0; p < 14; p++) step(1'b1, p == 0, pix(p));
        do_reset();
        chk("t5_windows_before_rst", win_log.size() - s0, 2);
        s0 = win_log.size();
        run_frame(1'b0, 1'b0, 5);
        idle(2);
        chk("t5_window_count", win_log.size() - s0, 6);
        chk_vec("t5_first_window", win_at(s0).data, lit_win(5));

        // Randomized: random pixel values, gaps and occasional mid-frame sof
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < IMG_W * IMG_H; p++) begin
                logic [PW-1:0] v;
                bit            s;
                while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, '0);
                v = PW'($urandom);
                s = (f == 0 && p == 0) || ($urandom_range(0, 39) == 0);
                step(1'b1, s, v);
            end
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
